proc_wr_buffer: RTL and testbench

PROC_WR_BUFFER -- requirements
Module: proc_wr_buffer

---
 rtl/proc_wr_buffer.sv | 164 ++++++++++++++++
 tb/tb_proc_wr_buffer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_wr_buffer.sv
// proc_wr_buffer: write-back buffer between a pixel processing stage and a bus master.
// Words from the processing stage land in a first-word-fall-through FIFO; a small
// FSM drains them as bursts of up to BURST_LEN beats to consecutive addresses.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   wr, data_out               write strobe and word from the processing stage
//   fifo_empty/full/count      FIFO occupancy status
//   start, base_addr           load the output address pointer (honoured in IDLE)
//   flush                      level; allows a partial burst of whatever is queued
//   mstr_req, mstr_gnt         bus request / grant
//   mstr_addr, mstr_wdata      current beat address and data (head of FIFO)
//   mstr_valid, mstr_ready     beat handshake
//   burst_done                 one-cycle pulse after the final beat of a burst
//   overflow                   sticky flag for a write dropped while full
module proc_wr_buffer #(
    parameter int unsigned D_WIDTH   = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr,
    input  logic [D_WIDTH-1:0]         data_out,
    output logic                       fifo_empty,
    output logic                       fifo_full,
    output logic [$clog2(DEPTH):0]     fifo_count,
    input  logic                       start,
    input  logic [31:0]                base_addr,
    input  logic                       flush,
    output logic                       mstr_req,
    input  logic                       mstr_gnt,
    output logic [31:0]                mstr_addr,
    output logic [D_WIDTH-1:0]         mstr_wdata,
    output logic                       mstr_valid,
    input  logic                       mstr_ready,
    output logic                       burst_done,
    output logic                       overflow
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned CW        = AW + 1;
    localparam logic [31:0] ADDR_STEP = 32'(D_WIDTH / 8);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [D_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count_nxt;
    logic [CW-1:0]      beats_left, beats_left_nxt;
    logic [31:0]        addr_nxt;
    logic               overflow_nxt;
    logic               push, pop;

    // Full is the registered flag, so a pop in the same cycle cannot make room for a write.
    assign push = wr && !fifo_full;
    assign pop  = (state == XFER) && mstr_ready;

    assign count_nxt = fifo_count + CW'(push) - CW'(pop);

    // Head entry is always presented on the bus data lines.
    assign mstr_wdata = mem[rd_ptr];

    // FIFO storage; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= data_out;
        end
    end

    // FIFO pointers and occupancy flags; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= count_nxt;
            fifo_empty <= (count_nxt == '0);
            fifo_full  <= (count_nxt == CW'(DEPTH));
        end
    end

    // Burst FSM next-state and datapath updates.
    always_comb begin
        state_nxt      = state;
        beats_left_nxt = beats_left;
        addr_nxt       = mstr_addr;
        overflow_nxt   = overflow;
        case (state)
            IDLE: begin
                if (start) begin
                    addr_nxt     = base_addr;
                    overflow_nxt = 1'b0;
                end
                if ((fifo_count >= CW'(BURST_LEN)) || (flush && !fifo_empty)) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                // No pops happen outside XFER, so the latched length never exceeds occupancy.
                if (mstr_gnt) begin
                    beats_left_nxt = (fifo_count >= CW'(BURST_LEN)) ? CW'(BURST_LEN) : fifo_count;
                    state_nxt      = XFER;
                end
            end
            XFER: begin
                if (mstr_ready) begin
                    beats_left_nxt = beats_left - CW'(1);
                    addr_nxt       = mstr_addr + ADDR_STEP;
                    if (beats_left == CW'(1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // A drop in the same cycle as start still leaves the flag set.
        if (wr && fifo_full) begin
            overflow_nxt = 1'b1;
        end
    end

    // State register; bus outputs are registered decodes of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beats_left <= '0;
            mstr_addr  <= '0;
            overflow   <= 1'b0;
            mstr_req   <= 1'b0;
            mstr_valid <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            beats_left <= beats_left_nxt;
            mstr_addr  <= addr_nxt;
            overflow   <= overflow_nxt;
            mstr_req   <= (state_nxt == REQ) || (state_nxt == XFER);
            mstr_valid <= (state_nxt == XFER);
            burst_done <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_proc_wr_buffer.sv
// Self-checking bench for proc_wr_buffer: directed scenarios plus random traffic,
// scored against a queue-based reference model in a negedge monitor.
module tb_proc_wr_buffer;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned BL    = 4;

    logic          clk;
    logic          rst_n;
    logic          wr;
    logic [DW-1:0] data_out;
    logic          fifo_empty;
    logic          fifo_full;
    logic [4:0]    fifo_count;
    logic          start;
    logic [31:0]   base_addr;
    logic          flush;
    logic          mstr_req;
    logic          mstr_gnt;
    logic [31:0]   mstr_addr;
    logic [DW-1:0] mstr_wdata;
    logic          mstr_valid;
    logic          mstr_ready;
    logic          burst_done;
    logic          overflow;

    proc_wr_buffer #(.D_WIDTH(DW), .DEPTH(DEPTH), .BURST_LEN(BL)) dut (
        .clk(clk), .rst_n(rst_n), .wr(wr), .data_out(data_out),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_count(fifo_count),
        .start(start), .base_addr(base_addr), .flush(flush),
        .mstr_req(mstr_req), .mstr_gnt(mstr_gnt), .mstr_addr(mstr_addr),
        .mstr_wdata(mstr_wdata), .mstr_valid(mstr_valid), .mstr_ready(mstr_ready),
        .burst_done(burst_done), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] exp_q [$];
    logic [31:0]   exp_addr = '0;
    bit            exp_ovf = 1'b0;
    int            exp_burst_len = 0;
    int            burst_beats = 0;
    int            bursts_done = 0;
    int            max_count = 0;
    bit            prev_stall = 1'b0;
    bit            prev_beat = 1'b0;
    logic [31:0]   prev_addr = '0;
    logic [DW-1:0] prev_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor / scoreboard: compare outputs with the model, then apply this cycle's events.
    always @(negedge clk) begin
        int occ;
        bit beat;
        occ  = exp_q.size();
        beat = 1'b0;
        if (!rst_n) begin
            chk("rst_empty", 64'(fifo_empty), 64'd1);
            chk("rst_full", 64'(fifo_full), 64'd0);
            chk("rst_count", 64'(fifo_count), 64'd0);
            chk("rst_req", 64'(mstr_req), 64'd0);
            chk("rst_valid", 64'(mstr_valid), 64'd0);
            chk("rst_addr", 64'(mstr_addr), 64'd0);
            chk("rst_wdata", 64'(mstr_wdata), 64'd0);
            chk("rst_done", 64'(burst_done), 64'd0);
            chk("rst_ovf", 64'(overflow), 64'd0);
            exp_q.delete();
            exp_addr      = '0;
            exp_ovf       = 1'b0;
            exp_burst_len = 0;
            burst_beats   = 0;
            prev_stall    = 1'b0;
            prev_beat     = 1'b0;
        end else begin
            if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
            chk("count", 64'(fifo_count), 64'(occ));
            chk("empty", 64'(fifo_empty), 64'(occ == 0));
            chk("full", 64'(fifo_full), 64'(occ == int'(DEPTH)));
            chk("overflow", 64'(overflow), 64'(exp_ovf));
            if (occ > 0) chk("head", 64'(mstr_wdata), 64'(exp_q[0]));
            if (prev_stall && mstr_valid) begin
                chk("hold_addr", 64'(mstr_addr), 64'(prev_addr));
                chk("hold_data", 64'(mstr_wdata), 64'(prev_data));
            end
            if (mstr_req && !mstr_valid && mstr_gnt) begin
                exp_burst_len = (occ < int'(BL)) ? occ : int'(BL);
            end
            if (mstr_valid) chk("valid_req", 64'(mstr_req), 64'd1);
            if (mstr_valid && mstr_ready) begin
                beat = 1'b1;
                chk("beat_expected", 64'(occ > 0), 64'd1);
                if (occ > 0) begin
                    chk("beat_data", 64'(mstr_wdata), 64'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
                chk("beat_addr", 64'(mstr_addr), 64'(exp_addr));
                exp_addr    = exp_addr + 32'(DW / 8);
                burst_beats = burst_beats + 1;
            end
            if (burst_done) begin
                chk("burst_len", 64'(burst_beats), 64'(exp_burst_len));
                chk("done_req_low", 64'(mstr_req), 64'd0);
                chk("done_after_beat", 64'(prev_beat), 64'd1);
                burst_beats = 0;
                bursts_done++;
            end
            prev_stall = mstr_valid && !mstr_ready;
            prev_beat  = beat;
            prev_addr  = mstr_addr;
            prev_data  = mstr_wdata;
            // Events taking effect at the coming edge (start is only issued while idle).
            if (start) begin
                exp_addr = base_addr;
                exp_ovf  = 1'b0;
            end
            if (wr) begin
                if (occ == int'(DEPTH)) exp_ovf = 1'b1;
                else exp_q.push_back(data_out);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        wr       = 1'b1;
        data_out = d;
        tick();
        wr       = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] a);
        start     = 1'b1;
        base_addr = a;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_quiet();
        int quiet = 0;
        for (int n = 0; n < 2000 && quiet < 3; n++) begin
            tick();
            if (fifo_empty && !mstr_req && !mstr_valid && !burst_done) quiet++;
            else quiet = 0;
        end
        chk("quiet_timeout", 64'(quiet >= 3), 64'd1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!mstr_valid && n < 200) begin
            tick();
            n++;
        end
        chk("valid_timeout", 64'(mstr_valid), 64'd1);
    endtask

    initial begin
        int            b0;
        logic [31:0]   a_hold;
        logic [DW-1:0] d_hold;
        logic [4:0]    c_hold;
        rst_n = 1'b0; wr = 1'b0; data_out = '0; start = 1'b0; base_addr = '0;
        flush = 1'b0; mstr_gnt = 1'b0; mstr_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Full burst from 0x1000
        mstr_gnt = 1'b1; mstr_ready = 1'b1;
        b0 = bursts_done;
        do_start(32'h1000);
        for (int i = 0; i < 4; i++) write_word(DW'(32'hA0 + i));
        wait_quiet();
        chk("full_burst_count", 64'(bursts_done - b0), 64'd1);
        chk("full_burst_empty", 64'(fifo_empty), 64'd1);
        chk("full_burst_addr", 64'(mstr_addr), 64'h1010);

        // Backpressure during beat 2
        mstr_ready = 1'b0;
        for (int i = 0; i < 4; i++) write_word(DW'(32'hB0 + i));
        wait_valid();
        mstr_ready = 1'b1;
        tick();
        mstr_ready = 1'b0;
        a_hold = mstr_addr; d_hold = mstr_wdata; c_hold = fifo_count;
        repeat (3) tick();
        chk("bp_addr", 64'(mstr_addr), 64'(a_hold));
        chk("bp_data", 64'(mstr_wdata), 64'(d_hold));
        chk("bp_count", 64'(fifo_count), 64'(c_hold));
        chk("bp_addr_val", 64'(a_hold), 64'h1014);
        mstr_ready = 1'b1;
        wait_quiet();

        // Overflow: 17 writes with no grant
        mstr_gnt = 1'b0;
        do_start(32'h3000);
        for (int i = 0; i < 17; i++) write_word(DW'($urandom));
        chk("ovf_full", 64'(fifo_full), 64'd1);
        chk("ovf_count", 64'(fifo_count), 64'd16);
        chk("ovf_flag", 64'(overflow), 64'd1);
        mstr_gnt = 1'b1;
        wait_quiet();
        chk("ovf_sticky", 64'(overflow), 64'd1);
        do_start(32'h4000);
        chk("ovf_cleared", 64'(overflow), 64'd0);

        // Flush: partial burst of 2, then 3 words without flush stay put
        b0 = bursts_done;
        write_word(DW'(32'hC0));
        write_word(DW'(32'hC1));
        flush = 1'b1;
        wait_quiet();
        flush = 1'b0;
        chk("flush_bursts", 64'(bursts_done - b0), 64'd1);
        for (int i = 0; i < 3; i++) write_word(DW'(32'hD0 + i));
        repeat (10) tick();
        chk("noflush_req", 64'(mstr_req), 64'd0);
        chk("noflush_count", 64'(fifo_count), 64'd3);
        flush = 1'b1;
        wait_quiet();
        flush = 1'b0;

        // Reset after beat 1, then restart
        do_start(32'h5000);
        for (int i = 0; i < 4; i++) write_word(DW'(32'hE0 + i));
        wait_valid();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(mstr_valid), 64'd0);
        chk("mid_rst_count", 64'(fifo_count), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        do_start(32'h6000);
        for (int i = 0; i < 4; i++) write_word(DW'(32'hF0 + i));
        wait_quiet();
        chk("restart_addr", 64'(mstr_addr), 64'h6010);

        // Continuous stream of 40 words
        do_start(32'h7000);
        for (int i = 0; i < 40; i++) begin
            wr = 1'b1;
            data_out = DW'($urandom);
            tick();
        end
        wr = 1'b0;
        flush = 1'b1;
        wait_quiet();
        flush = 1'b0;
        chk("max_count", 64'(max_count <= int'(DEPTH)), 64'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            wr         = ($urandom % 2) == 0;
            data_out   = DW'($urandom);
            mstr_gnt   = ($urandom % 4) != 0;
            mstr_ready = ($urandom % 3) != 0;
            flush      = ($urandom % 8) == 0;
            tick();
        end
        wr = 1'b0; mstr_gnt = 1'b1; mstr_ready = 1'b1; flush = 1'b1;
        wait_quiet();
        flush = 1'b0;
        repeat (2) tick();
        chk("drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
